// File: rtl/wave_gen_pkg.sv
// Shared mode encodings and default widths for the waveform address generator.
package wave_gen_pkg;

  localparam int unsigned MODE_W       = 3;
  localparam logic [MODE_W-1:0] MODE_SINE = 3'b010;
  localparam logic [MODE_W-1:0] MODE_555  = 3'b001;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned FACTOR_W_DEF = 16;

endpackage

// File: rtl/wag_pulse_sync.sv
// Synchroniser for the asynchronous 555 pulse plus a rising-edge detector.
// The edge register always tracks the synchronised level, so a mode switch never sees a stale edge.
module wag_pulse_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = r_sync[SYNC_STAGES-1] & ~r_edge;

endmodule

// File: rtl/wave_addr_gen.sv
// Waveform LUT address generator: advances on a programmable divider tick or on 555 pulse edges.
// Define WAG_STEP_EN to add the `step` port (address increment = step instead of 1).
module wave_addr_gen
  import wave_gen_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned FACTOR_W    = FACTOR_W_DEF,
  parameter int unsigned FACTOR_RST  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MODE_W-1:0]   mode,
  input  logic                factor_wr,
  input  logic [FACTOR_W-1:0] factor,
  input  logic                ext_pulse,
  input  logic                addr_clr,
`ifdef WAG_STEP_EN
  input  logic [ADDR_W-1:0]   step,
`endif
  output logic [ADDR_W-1:0]   addr,
  output logic                tick,
  output logic                wrap,
  output logic [FACTOR_W-1:0] factor_active
);

  logic [FACTOR_W-1:0] r_div_cnt;
  logic [FACTOR_W-1:0] r_factor_pend;
  logic [FACTOR_W-1:0] r_factor_active;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_tick;
  logic                r_wrap;

  logic                w_level;
  logic                w_rise;
  logic                w_is_sine;
  logic                w_is_ext;
  logic                w_boundary;
  logic                w_ext_evt;
  logic                w_adv;
  logic [ADDR_W-1:0]   w_inc;
  logic [ADDR_W:0]     w_sum;

  wag_pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pulse_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ext_pulse),
    .level(w_level),
    .rise (w_rise)
  );

  assign w_is_sine  = (mode == MODE_SINE);
  assign w_is_ext   = (mode == MODE_555);
  assign w_boundary = w_is_sine && (r_div_cnt == (r_factor_active - FACTOR_W'(1)));
  assign w_ext_evt  = w_is_ext && w_rise && w_level;
  assign w_adv      = w_boundary || w_ext_evt;

`ifdef WAG_STEP_EN
  assign w_inc = step;
`else
  assign w_inc = ADDR_W'(1);
`endif

  // Carry bit of the sum is the wrap indication.
  assign w_sum = {1'b0, r_addr} + {1'b0, w_inc};

  // Divider and factor hand-over; outside sine mode the counter idles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt       <= '0;
      r_factor_pend   <= FACTOR_W'(FACTOR_RST);
      r_factor_active <= FACTOR_W'(FACTOR_RST);
    end else begin
      if (w_is_sine && !w_boundary) begin
        r_div_cnt <= r_div_cnt + FACTOR_W'(1);
      end else begin
        r_div_cnt <= '0;
      end
      if (factor_wr && (factor != '0)) begin
        r_factor_pend <= factor;
      end
      if (!w_is_sine || w_boundary) begin
        r_factor_active <= r_factor_pend;
      end
    end
  end

  // Address register; a clear overrides any advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (addr_clr) begin
      r_addr <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_adv) begin
      r_addr <= w_sum[ADDR_W-1:0];
      r_tick <= 1'b1;
      r_wrap <= w_sum[ADDR_W];
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign addr          = r_addr;
  assign tick          = r_tick;
  assign wrap          = r_wrap;
  assign factor_active = r_factor_active;

endmodule

// File: tb/tb_wave_addr_gen.sv
// Self-checking bench for wave_addr_gen: directed vector table, corner sequences and a randomized run.
module tb_wave_addr_gen;

  localparam int ADDR_W     = 10;
  localparam int DEPTH      = 1024;
  localparam int FACTOR_W   = 16;
  localparam int FACTOR_RST = 2;
  localparam int SYNC       = 2;

  logic                clk;
  logic                rst_n;
  logic [2:0]          mode;
  logic                factor_wr;
  logic [FACTOR_W-1:0] factor;
  logic                ext_pulse;
  logic                addr_clr;
`ifdef WAG_STEP_EN
  logic [ADDR_W-1:0]   step;
`endif
  logic [ADDR_W-1:0]   addr;
  logic                tick;
  logic                wrap;
  logic [FACTOR_W-1:0] factor_active;

  int n_chk;
  int n_fail;

  wave_addr_gen #(
    .ADDR_W     (ADDR_W),
    .FACTOR_W   (FACTOR_W),
    .FACTOR_RST (FACTOR_RST),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .factor_wr    (factor_wr),
    .factor       (factor),
    .ext_pulse    (ext_pulse),
    .addr_clr     (addr_clr),
`ifdef WAG_STEP_EN
    .step         (step),
`endif
    .addr         (addr),
    .tick         (tick),
    .wrap         (wrap),
    .factor_active(factor_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: period bookkeeping in cycles plus a history of sampled ext_pulse values.
  int m_addr;
  int m_active;
  int m_pend;
  int m_elapsed;
  bit m_tick;
  bit m_wrap;
  bit m_hist[$];

  function automatic void model_reset();
    m_addr = 0; m_active = FACTOR_RST; m_pend = FACTOR_RST; m_elapsed = 0;
    m_tick = 1'b0; m_wrap = 1'b0;
    m_hist = {};
    for (int k = 0; k < SYNC + 1; k++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit bnd;
    bit ev;
    int inc;
    int sum;
    int last;
    m_hist.push_back(ext_pulse);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    last = m_hist.size() - 1;
    // A rise sampled SYNC edges ago becomes visible now as a tick.
    bnd = (mode == 3'b010) && (m_elapsed + 1 == m_active);
    ev  = (mode == 3'b001) && m_hist[last - SYNC] && !m_hist[last - SYNC - 1];
`ifdef WAG_STEP_EN
    inc = int'(step);
`else
    inc = 1;
`endif
    if (addr_clr) begin
      m_addr = 0; m_tick = 1'b0; m_wrap = 1'b0;
    end else if (bnd || ev) begin
      sum = m_addr + inc;
      m_tick = 1'b1;
      m_wrap = (sum >= DEPTH);
      m_addr = sum % DEPTH;
    end else begin
      m_tick = 1'b0; m_wrap = 1'b0;
    end
    if (mode != 3'b010 || bnd) m_active = m_pend;
    if (factor_wr && factor != 0) m_pend = int'(factor);
    m_elapsed = (mode == 3'b010 && !bnd) ? m_elapsed + 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit cmp, input string tag);
    @(posedge clk);
    model_step();
    #1;
    if (cmp) begin
      chk({tag, "_addr"},  32'(addr),          32'(m_addr));
      chk({tag, "_tick"},  32'(tick),          32'(m_tick));
      chk({tag, "_wrap"},  32'(wrap),          32'(m_wrap));
      chk({tag, "_fact"},  32'(factor_active), 32'(m_active));
    end
  endtask

  task automatic do_reset(input bit cmp, input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    if (cmp) begin
      chk({tag, "_rst_addr"}, 32'(addr),          32'd0);
      chk({tag, "_rst_tick"}, 32'(tick),          32'd0);
      chk({tag, "_rst_wrap"}, 32'(wrap),          32'd0);
      chk({tag, "_rst_fact"}, 32'(factor_active), 32'(FACTOR_RST));
    end
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]          mode;
    logic                wr;
    logic [FACTOR_W-1:0] fac;
    logic                clr;
    logic                exp_tick;
    logic [ADDR_W-1:0]   exp_addr;
    logic                exp_wrap;
    logic [FACTOR_W-1:0] exp_act;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [2:0] m, input logic wr, input int fac, input logic clr,
                              input logic t, input int a, input logic w, input int act);
    vec_t v;
    v.mode = m; v.wr = wr; v.fac = FACTOR_W'(fac); v.clr = clr;
    v.exp_tick = t; v.exp_addr = ADDR_W'(a); v.exp_wrap = w; v.exp_act = FACTOR_W'(act);
    vecs.push_back(v);
  endfunction

  int ticks;
  int ext_left;
  int mode_left;
  int r;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; mode = 3'b000; factor_wr = 1'b0; factor = '0;
    ext_pulse = 1'b0; addr_clr = 1'b0;
`ifdef WAG_STEP_EN
    step = ADDR_W'(1);
`endif
    model_reset();
    #12;
    chk("init_addr", 32'(addr), 32'd0);
    chk("init_tick", 32'(tick), 32'd0);
    chk("init_wrap", 32'(wrap), 32'd0);
    chk("init_fact", 32'(factor_active), 32'(FACTOR_RST));
    rst_n = 1'b1;

    // Directed table: factor 2 cadence, factor change mid-period, zero factor, write at boundary, clear, hold.
    add(3'b010, 0, 0, 0, 0, 0, 0, 2);
    add(3'b010, 0, 0, 0, 1, 1, 0, 2);
    add(3'b010, 1, 5, 0, 0, 1, 0, 2);
    add(3'b010, 0, 0, 0, 1, 2, 0, 5);
    repeat (4) add(3'b010, 0, 0, 0, 0, 2, 0, 5);
    add(3'b010, 0, 0, 0, 1, 3, 0, 5);
    add(3'b010, 1, 0, 0, 0, 3, 0, 5);
    repeat (3) add(3'b010, 0, 0, 0, 0, 3, 0, 5);
    add(3'b010, 0, 0, 0, 1, 4, 0, 5);
    repeat (4) add(3'b010, 0, 0, 0, 0, 4, 0, 5);
    add(3'b010, 1, 3, 0, 1, 5, 0, 5);
    repeat (4) add(3'b010, 0, 0, 0, 0, 5, 0, 5);
    add(3'b010, 0, 0, 0, 1, 6, 0, 3);
    repeat (2) add(3'b010, 0, 0, 0, 0, 6, 0, 3);
    add(3'b010, 0, 0, 1, 0, 0, 0, 3);
    repeat (2) add(3'b010, 0, 0, 0, 0, 0, 0, 3);
    add(3'b010, 0, 0, 0, 1, 1, 0, 3);
    repeat (2) add(3'b000, 0, 0, 0, 0, 1, 0, 3);
    add(3'b000, 0, 0, 1, 0, 0, 0, 3);
    repeat (2) add(3'b010, 0, 0, 0, 0, 0, 0, 3);
    add(3'b010, 0, 0, 0, 1, 1, 0, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode; factor_wr = vecs[i].wr; factor = vecs[i].fac; addr_clr = vecs[i].clr;
      cycle(1'b1, "vecm");
      chk($sformatf("vec%0d_tick", i), 32'(tick),          32'(vecs[i].exp_tick));
      chk($sformatf("vec%0d_addr", i), 32'(addr),          32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap),          32'(vecs[i].exp_wrap));
      chk($sformatf("vec%0d_fact", i), 32'(factor_active), 32'(vecs[i].exp_act));
    end
    factor_wr = 1'b0; addr_clr = 1'b0; factor = '0;

    // Full address sweep at the reset factor: 1024 ticks end in a wrap to 0.
    mode = 3'b000;
    do_reset(1'b1, "sweep");
    mode = 3'b010;
    ticks = 0;
    for (int c = 0; c < 2200 && ticks < DEPTH; c++) begin
      cycle(1'b0, "sweep");
      if (tick) begin
        ticks++;
        if (ticks == DEPTH - 1) begin
          chk("sweep_addr_max", 32'(addr), 32'(DEPTH - 1));
          chk("sweep_nowrap",   32'(wrap), 32'd0);
        end
        if (ticks == DEPTH) begin
          chk("sweep_addr_wrap", 32'(addr), 32'd0);
          chk("sweep_wrap",      32'(wrap), 32'd1);
        end
      end
    end
    chk("sweep_tick_count", 32'(ticks), 32'(DEPTH));

    // External pulse: square wave of period 40, tick lands SYNC+1 edges after the rise.
    mode = 3'b000;
    do_reset(1'b0, "ext");
    mode = 3'b001;
    repeat (3) cycle(1'b1, "ext_idle");
    for (int p = 0; p < 3; p++) begin
      ext_pulse = 1'b1;
      for (int e = 1; e <= SYNC + 2; e++) begin
        cycle(1'b1, "ext_m");
        chk($sformatf("ext%0d_lat%0d_tick", p, e), 32'(tick), (e == SYNC + 1) ? 32'd1 : 32'd0);
      end
      chk($sformatf("ext%0d_addr", p), 32'(addr), 32'(p + 1));
      repeat (16) cycle(1'b1, "ext_hi");
      ext_pulse = 1'b0;
      repeat (20) cycle(1'b1, "ext_lo");
    end
    // Hold mode freezes the address even while pulses continue.
    mode = 3'b000;
    for (int p = 0; p < 2; p++) begin
      ext_pulse = 1'b1;
      repeat (20) cycle(1'b1, "hold_hi");
      ext_pulse = 1'b0;
      repeat (20) cycle(1'b1, "hold_lo");
    end
    chk("hold_addr", 32'(addr), 32'd3);
    // Entering 555 mode while the pulse is already high must not tick.
    ext_pulse = 1'b1;
    repeat (6) cycle(1'b1, "pre_entry");
    mode = 3'b001;
    ticks = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, "entry");
      if (tick) ticks++;
    end
    chk("entry_no_tick", 32'(ticks), 32'd0);
    ext_pulse = 1'b0;

`ifdef WAG_STEP_EN
    // Phase-step mode: step 300 with factor 1, then step 0, then reset mid-run.
    mode = 3'b000;
    do_reset(1'b0, "step");
    step = ADDR_W'(300);
    factor_wr = 1'b1; factor = FACTOR_W'(1);
    cycle(1'b1, "step_ld");
    factor_wr = 1'b0; factor = '0;
    cycle(1'b1, "step_ld");
    chk("step_fact", 32'(factor_active), 32'd1);
    mode = 3'b010;
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, "step_m");
      chk($sformatf("step%0d_addr", k), 32'(addr), 32'((300 * k) % DEPTH));
      chk($sformatf("step%0d_tick", k), 32'(tick), 32'd1);
      chk($sformatf("step%0d_wrap", k), 32'(wrap), (k == 4) ? 32'd1 : 32'd0);
    end
    step = '0;
    cycle(1'b1, "step0");
    chk("step0_tick", 32'(tick), 32'd1);
    chk("step0_addr", 32'(addr), 32'd176);
    chk("step0_wrap", 32'(wrap), 32'd0);
    step = ADDR_W'(300);
    repeat (3) cycle(1'b1, "step_run");
    do_reset(1'b1, "step_mid");
    step = ADDR_W'(1);
`endif

    // Mid-period reset aborts the period: outputs return to reset values immediately.
    mode = 3'b010;
    repeat (7) cycle(1'b1, "mid");
    do_reset(1'b1, "mid");

    // Randomized run against the reference model.
    ext_left = 0; mode_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mode_left == 0) begin
        r = int'($urandom_range(0, 9));
        mode = (r < 5) ? 3'b010 : (r < 8) ? 3'b001 : (r == 8) ? 3'b000 : 3'b011;
        mode_left = int'($urandom_range(5, 60));
`ifdef WAG_STEP_EN
        step = ADDR_W'($urandom_range(0, DEPTH - 1));
`endif
      end else begin
        mode_left--;
      end
      factor_wr = ($urandom_range(0, 15) == 0);
      factor    = FACTOR_W'($urandom_range(0, 4));
      addr_clr  = ($urandom_range(0, 39) == 0);
      if (ext_left == 0) begin
        ext_pulse = ~ext_pulse;
        ext_left  = int'($urandom_range(1, 6));
      end else begin
        ext_left--;
      end
      if ($urandom_range(0, 599) == 0) do_reset(1'b1, "rnd");
      cycle(1'b1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
